// File: rtl/axil_cfg_seq_master.sv
// axil_cfg_seq_master
// AXI4-Lite master that writes an incrementing configuration pattern into
// NUM_REGS consecutive 32-bit registers, reads every register back, and
// reports completion, a sticky error flag and a saturating error count.
// Only one transaction is ever outstanding, so all channel outputs can be
// decoded from the sequencer state plus two per-write handshake flags.
module axil_cfg_seq_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] SEED               = 32'h0000_0001
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            INIT_TXN,
  output logic                            TXN_DONE,
  output logic                            TXN_ERROR,
  output logic [4:0]                      ERR_COUNT,
  output logic                            BUSY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  // Index wide enough for up to 16 registers.
  localparam int                IDX_W    = 4;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [4:0]        ERR_MAX  = 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_RESP,
    DONE
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic                            init_q;
  logic                            start_edge;
  logic                            start_accept;
  logic [IDX_W-1:0]                idx;
  logic                            is_last;
  logic                            aw_done;
  logic                            w_done;
  logic                            aw_hs;
  logic                            w_hs;
  logic                            wr_both_done;
  logic                            b_hs;
  logic                            ar_hs;
  logic                            r_hs;
  logic                            wr_beat_bad;
  logic                            rd_beat_bad;
  logic                            err_inc;
  logic [4:0]                      err_count;
  logic                            txn_error;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_cur;
  logic [C_M_AXI_DATA_WIDTH-1:0]   data_cur;

  // Address and pattern value for the register currently addressed by idx.
  assign addr_cur = BASE_ADDR + {{(C_M_AXI_ADDR_WIDTH-IDX_W-2){1'b0}}, idx, 2'b00};
  assign data_cur = SEED + {{(C_M_AXI_DATA_WIDTH-IDX_W){1'b0}}, idx};
  assign is_last  = (idx == LAST_IDX);

  // A start is a low-to-high transition of INIT_TXN, honoured only when idle or finished.
  assign start_edge   = INIT_TXN & ~init_q;
  assign start_accept = start_edge & ((state == IDLE) | (state == DONE));

  // Channel handshakes; the VALID/READY outputs depend only on registered state.
  assign aw_hs        = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs         = M_AXI_WVALID & M_AXI_WREADY;
  assign wr_both_done = (aw_done | aw_hs) & (w_done | w_hs);
  assign b_hs         = M_AXI_BVALID & M_AXI_BREADY;
  assign ar_hs        = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs         = M_AXI_RVALID & M_AXI_RREADY;

  // A bad read beat counts once even if both the response and the data are wrong.
  assign wr_beat_bad = b_hs & (M_AXI_BRESP != 2'b00);
  assign rd_beat_bad = r_hs & ((M_AXI_RRESP != 2'b00) | (M_AXI_RDATA != data_cur));
  assign err_inc     = wr_beat_bad | rd_beat_bad;

  // State register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: one write (AW+W then B) per register, then one read per register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_accept) state_next = WR;
      end
      WR: begin
        if (wr_both_done) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) state_next = is_last ? RD : WR;
      end
      RD: begin
        if (ar_hs) state_next = RD_RESP;
      end
      RD_RESP: begin
        if (r_hs) state_next = is_last ? DONE : RD;
      end
      DONE: begin
        if (start_accept) state_next = WR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; addresses, data and strobes are zero outside the phase that presents them.
  always_comb begin
    M_AXI_AWADDR  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    BUSY          = 1'b0;
    TXN_DONE      = 1'b0;
    case (state)
      WR: begin
        M_AXI_AWADDR  = addr_cur;
        M_AXI_AWVALID = ~aw_done;
        M_AXI_WDATA   = data_cur;
        M_AXI_WSTRB   = '1;
        M_AXI_WVALID  = ~w_done;
        BUSY          = 1'b1;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        BUSY         = 1'b1;
      end
      RD: begin
        M_AXI_ARADDR  = addr_cur;
        M_AXI_ARVALID = 1'b1;
        BUSY          = 1'b1;
      end
      RD_RESP: begin
        M_AXI_RREADY = 1'b1;
        BUSY         = 1'b1;
      end
      DONE: begin
        TXN_DONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign ERR_COUNT    = err_count;
  assign TXN_ERROR    = txn_error;

  // INIT_TXN history for rising-edge detection.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      init_q <= 1'b0;
    end else begin
      init_q <= INIT_TXN;
    end
  end

  // Register index: wraps to 0 between the write pass and the read pass.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      idx <= '0;
    end else if (start_accept) begin
      idx <= '0;
    end else if (b_hs) begin
      idx <= is_last ? '0 : idx + 1'b1;
    end else if (r_hs && !is_last) begin
      idx <= idx + 1'b1;
    end
  end

  // Per-write AW/W completion flags so each VALID drops right after its own handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != WR) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Error bookkeeping: cleared on an accepted start, count saturates, flag is sticky.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      err_count <= '0;
      txn_error <= 1'b0;
    end else if (start_accept) begin
      err_count <= '0;
      txn_error <= 1'b0;
    end else if (err_inc) begin
      txn_error <= 1'b1;
      if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_cfg_seq_master.sv
// tb_axil_cfg_seq_master
// Drives the sequencer against a configurable AXI4-Lite slave model with
// programmable channel latencies and fault injection, and compares the
// observed writes, reads and status against a model of the intended sequence.
module tb_axil_cfg_seq_master;

  localparam int          NREG   = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] SEED_V = 32'h0000_0001;
  localparam int          OUT_W  = 119;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        INIT_TXN = 1'b0;
  logic        TXN_DONE, TXN_ERROR, BUSY;
  logic [4:0]  ERR_COUNT;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axil_cfg_seq_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .NUM_REGS(NREG),
    .BASE_ADDR(BASE),
    .SEED(SEED_V)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .INIT_TXN(INIT_TXN),
    .TXN_DONE(TXN_DONE), .TXN_ERROR(TXN_ERROR), .ERR_COUNT(ERR_COUNT), .BUSY(BUSY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Slave model configuration and transaction log.
  int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
  bit          lat_rand;
  logic [15:0] bresp_err_mask, rresp_err_mask, rdata_bad_mask;
  logic [31:0] mem [16];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];

  // Slave model internal state.
  logic        p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic        aw_have, w_have, wr_logged, ar_have;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

  function automatic logic [OUT_W-1:0] all_outs();
    return {TXN_DONE, TXN_ERROR, ERR_COUNT, BUSY, M_AXI_AWADDR, M_AXI_AWPROT,
            M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
            M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY};
  endfunction

  // Reference model: every failing beat counts once, saturating at 31.
  function automatic int model_errors(input logic [15:0] bm, input logic [15:0] rm,
                                      input logic [15:0] dm);
    int n = 0;
    for (int i = 0; i < NREG; i++) begin
      if (bm[i]) n++;
      if (rm[i] || dm[i]) n++;
    end
    return (n > 31) ? 31 : n;
  endfunction

  task automatic pick_lat();
    if (lat_rand) begin
      aw_lat = $urandom_range(0, 3);
      w_lat  = $urandom_range(0, 3);
      b_lat  = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3);
      r_lat  = $urandom_range(0, 3);
    end
  endtask

  task automatic set_slave(input int aw, input int w, input int b, input int ar,
                           input int r, input bit rnd);
    aw_lat = aw; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r; lat_rand = rnd;
    pick_lat();
  endtask

  task automatic slave_clear();
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0;
    aw_have = 0; w_have = 0; wr_logged = 0; ar_have = 0;
    s_awaddr = 0; s_wdata = 0; s_araddr = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    pick_lat();
  endtask

  // One slave cycle at the falling edge: account for handshakes taken at the
  // rising edge just gone, check master protocol, then drive the next READY/VALIDs.
  task automatic slave_step();
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
    hs_aw = p_awvalid && M_AXI_AWREADY;
    hs_w  = p_wvalid && M_AXI_WREADY;
    hs_b  = p_bready && M_AXI_BVALID;
    hs_ar = p_arvalid && M_AXI_ARREADY;
    hs_r  = p_rready && M_AXI_RVALID;
    if (p_awvalid) begin
      tests_run++;
      if (hs_aw ? (M_AXI_AWVALID !== 1'b0)
                : (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== p_awaddr)) begin
        tests_failed++;
        $display("[TB] FAIL proto_aw: AWVALID=%b AWADDR=%h, required %b / %h",
                 M_AXI_AWVALID, M_AXI_AWADDR, !hs_aw, p_awaddr);
      end
    end
    if (p_wvalid) begin
      tests_run++;
      if (hs_w ? (M_AXI_WVALID !== 1'b0)
               : (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== p_wdata)) begin
        tests_failed++;
        $display("[TB] FAIL proto_w: WVALID=%b WDATA=%h, required %b / %h",
                 M_AXI_WVALID, M_AXI_WDATA, !hs_w, p_wdata);
      end
    end
    if (p_arvalid) begin
      tests_run++;
      if (hs_ar ? (M_AXI_ARVALID !== 1'b0)
                : (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== p_araddr)) begin
        tests_failed++;
        $display("[TB] FAIL proto_ar: ARVALID=%b ARADDR=%h, required %b / %h",
                 M_AXI_ARVALID, M_AXI_ARADDR, !hs_ar, p_araddr);
      end
    end
    if (p_bready) begin
      tests_run++;
      if (M_AXI_BREADY !== !hs_b) begin
        tests_failed++;
        $display("[TB] FAIL proto_b: BREADY=%b, required %b", M_AXI_BREADY, !hs_b);
      end
    end
    if (p_rready) begin
      tests_run++;
      if (M_AXI_RREADY !== !hs_r) begin
        tests_failed++;
        $display("[TB] FAIL proto_r: RREADY=%b, required %b", M_AXI_RREADY, !hs_r);
      end
    end
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    if (hs_aw) begin aw_have = 1; s_awaddr = p_awaddr; end
    if (hs_w)  begin w_have = 1;  s_wdata = p_wdata; end
    if (aw_have && w_have && !wr_logged) begin
      wr_addr_q.push_back(s_awaddr);
      wr_data_q.push_back(s_wdata);
      mem[s_awaddr[5:2]] = s_wdata;
      wr_logged = 1;
      b_cnt = 0;
    end
    if (hs_b) begin
      M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      aw_have = 0; w_have = 0; wr_logged = 0; aw_cnt = 0; w_cnt = 0;
      pick_lat();
    end else if (wr_logged && !M_AXI_BVALID) begin
      if (b_cnt >= b_lat) begin
        M_AXI_BVALID = 1;
        M_AXI_BRESP  = bresp_err_mask[s_awaddr[5:2]] ? 2'b10 : 2'b00;
      end else b_cnt++;
    end
    if (!aw_have && M_AXI_AWVALID) begin
      if (aw_cnt >= aw_lat) M_AXI_AWREADY = 1; else aw_cnt++;
    end
    if (!w_have && M_AXI_WVALID) begin
      if (w_cnt >= w_lat) M_AXI_WREADY = 1; else w_cnt++;
    end
    if (hs_ar) begin
      ar_have = 1; s_araddr = p_araddr; rd_addr_q.push_back(p_araddr); r_cnt = 0;
    end
    if (hs_r) begin
      M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      ar_have = 0; ar_cnt = 0;
      pick_lat();
    end else if (ar_have && !M_AXI_RVALID) begin
      if (r_cnt >= r_lat) begin
        M_AXI_RVALID = 1;
        M_AXI_RRESP  = rresp_err_mask[s_araddr[5:2]] ? 2'b10 : 2'b00;
        M_AXI_RDATA  = rdata_bad_mask[s_araddr[5:2]] ? 32'hDEAD_BEEF : mem[s_araddr[5:2]];
      end else r_cnt++;
    end
    if (!ar_have && M_AXI_ARVALID) begin
      if (ar_cnt >= ar_lat) M_AXI_ARREADY = 1; else ar_cnt++;
    end
    p_awvalid = M_AXI_AWVALID; p_awaddr = M_AXI_AWADDR;
    p_wvalid  = M_AXI_WVALID;  p_wdata  = M_AXI_WDATA;
    p_arvalid = M_AXI_ARVALID; p_araddr = M_AXI_ARADDR;
    p_bready  = M_AXI_BREADY;  p_rready = M_AXI_RREADY;
  endtask

  initial begin
    bresp_err_mask = 0; rresp_err_mask = 0; rdata_bad_mask = 0;
    set_slave(0, 0, 0, 0, 0, 0);
    slave_clear();
    forever begin
      @(negedge ACLK);
      if (ARESETN !== 1'b1) slave_clear();
      else slave_step();
    end
  end

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
  endtask

  task automatic pulse_init();
    @(posedge ACLK); #2 INIT_TXN = 1'b1;
    @(posedge ACLK); #2 INIT_TXN = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc, output bit ok);
    ok = 0; cyc = 0;
    while (!ok && cyc < bound) begin
      @(posedge ACLK); #1;
      cyc++;
      if (TXN_DONE === 1'b1) ok = 1;
    end
  endtask

  // Full sequence with the given fault masks, checked against the model.
  task automatic run_sequence(input string name, input logic [15:0] bm,
                              input logic [15:0] rm, input logic [15:0] dm, input int bound);
    int cyc; bit ok; int exp_err;
    bresp_err_mask = bm; rresp_err_mask = rm; rdata_bad_mask = dm;
    exp_err = model_errors(bm, rm, dm);
    clear_log();
    pulse_init();
    tests_run++;
    if ({BUSY, TXN_DONE, TXN_ERROR, ERR_COUNT, M_AXI_AWVALID, M_AXI_WVALID,
         M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !==
        {1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, BASE, SEED_V, 4'hF}) begin
      tests_failed++;
      $display("[TB] FAIL %s_start: busy=%b done=%b err=%b cnt=%0d awv=%b wv=%b aw=%h wd=%h strb=%h, required 1 0 0 0 1 1 %h %h f",
               name, BUSY, TXN_DONE, TXN_ERROR, ERR_COUNT, M_AXI_AWVALID, M_AXI_WVALID,
               M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, BASE, SEED_V);
    end
    wait_done(bound, cyc, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL %s_done: TXN_DONE not seen after %0d cycles, required within %0d",
               name, cyc, bound);
    end
    tests_run++;
    if ({TXN_DONE, BUSY, TXN_ERROR, ERR_COUNT} !== {1'b1, 1'b0, exp_err != 0, 5'(exp_err)}) begin
      tests_failed++;
      $display("[TB] FAIL %s_status: done=%b busy=%b err=%b cnt=%0d, required 1 0 %b %0d",
               name, TXN_DONE, BUSY, TXN_ERROR, ERR_COUNT, exp_err != 0, exp_err);
    end
    tests_run++;
    if (wr_addr_q.size() != NREG || rd_addr_q.size() != NREG) begin
      tests_failed++;
      $display("[TB] FAIL %s_beats: writes=%0d reads=%0d, required %0d each",
               name, wr_addr_q.size(), rd_addr_q.size(), NREG);
    end
    for (int i = 0; i < NREG && i < wr_addr_q.size(); i++) begin
      tests_run++;
      if (wr_addr_q[i] !== BASE + 32'(4*i) || wr_data_q[i] !== SEED_V + 32'(i)) begin
        tests_failed++;
        $display("[TB] FAIL %s_write%0d: addr=%h data=%h, required %h %h",
                 name, i, wr_addr_q[i], wr_data_q[i], BASE + 32'(4*i), SEED_V + 32'(i));
      end
    end
    for (int i = 0; i < NREG && i < rd_addr_q.size(); i++) begin
      tests_run++;
      if (rd_addr_q[i] !== BASE + 32'(4*i)) begin
        tests_failed++;
        $display("[TB] FAIL %s_read%0d: addr=%h, required %h", name, i, rd_addr_q[i],
                 BASE + 32'(4*i));
      end
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    tests_run++;
    if (all_outs() !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: outputs=%h, required 0", all_outs());
    end
    @(posedge ACLK); #2 ARESETN = 1'b1;
    @(posedge ACLK); #1;
    tests_run++;
    if (all_outs() !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: outputs=%h, required 0", all_outs());
    end
  endtask

  task automatic test_basic();
    set_slave(0, 0, 0, 0, 0, 0);
    run_sequence("basic", 0, 0, 0, 26);
  endtask

  task automatic test_handshake_order();
    set_slave(0, 3, 0, 0, 0, 0);
    run_sequence("w_late", 0, 0, 0, 80);
    set_slave(3, 0, 1, 2, 1, 0);
    run_sequence("aw_late", 0, 0, 0, 80);
    set_slave(2, 2, 2, 0, 2, 0);
    run_sequence("aw_w_same", 0, 0, 0, 80);
  endtask

  task automatic test_bad_rdata();
    set_slave(0, 0, 0, 0, 0, 0);
    run_sequence("bad_rdata", 0, 0, 16'h0004, 40);
  endtask

  task automatic test_slverr();
    set_slave(1, 0, 0, 1, 0, 0);
    run_sequence("slverr", 16'h000F, 16'h000F, 0, 60);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_slave(0, 0, 5, 0, 0, 0);
    bresp_err_mask = 0; rresp_err_mask = 0; rdata_bad_mask = 0;
    clear_log();
    pulse_init();
    while (M_AXI_BREADY !== 1'b1 && n < 20) begin
      @(posedge ACLK); #1; n++;
    end
    tests_run++;
    if (M_AXI_BREADY !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_reach: BREADY=%b after %0d cycles, required 1", M_AXI_BREADY, n);
    end
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    tests_run++;
    if (all_outs() !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs: outputs=%h, required 0", all_outs());
    end
    #1 ARESETN = 1'b1;
    set_slave(0, 0, 0, 0, 0, 0);
    run_sequence("after_reset", 0, 0, 0, 40);
  endtask

  task automatic test_toggle_busy();
    int cyc; bit ok;
    set_slave(1, 1, 0, 0, 0, 0);
    bresp_err_mask = 0; rresp_err_mask = 0; rdata_bad_mask = 16'h0001;
    clear_log();
    pulse_init();
    for (int k = 0; k < 6; k++) begin
      @(posedge ACLK); #2 INIT_TXN = ~INIT_TXN;
    end
    #1 INIT_TXN = 1'b0;
    wait_done(80, cyc, ok);
    tests_run++;
    if (!ok || wr_addr_q.size() != NREG || rd_addr_q.size() != NREG) begin
      tests_failed++;
      $display("[TB] FAIL toggle_busy_beats: done=%b writes=%0d reads=%0d, required 1 %0d %0d",
               ok, wr_addr_q.size(), rd_addr_q.size(), NREG, NREG);
    end
    tests_run++;
    if ({TXN_ERROR, ERR_COUNT} !== {1'b1, 5'd1}) begin
      tests_failed++;
      $display("[TB] FAIL toggle_busy_err: err=%b cnt=%0d, required 1 1", TXN_ERROR, ERR_COUNT);
    end
    repeat (3) @(posedge ACLK);
    #1;
    tests_run++;
    if ({TXN_DONE, BUSY, wr_addr_q.size() == NREG} !== {1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL toggle_hold_done: done=%b busy=%b writes=%0d, required 1 0 %0d",
               TXN_DONE, BUSY, wr_addr_q.size(), NREG);
    end
    set_slave(0, 0, 0, 0, 0, 0);
    run_sequence("rerun", 0, 0, 0, 40);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      set_slave(0, 0, 0, 0, 0, 1);
      run_sequence("random", 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                   16'($urandom_range(0, 15)), 200);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_handshake_order();
    test_bad_rdata();
    test_slverr();
    test_reset_mid();
    test_toggle_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
